// File: rtl/out_channel_pkg.sv
// Shared types for the out-channel drain stage: data word and FSM state encoding.
package out_channel_pkg;

   localparam int unsigned DefaultWordWidth = 12;

   typedef logic [DefaultWordWidth-1:0] word_t;

   typedef logic [1:0] state_t;

   localparam state_t RUN   = 2'd0;
   localparam state_t FLUSH = 2'd1;
   localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/out_fifo.sv
// Circular word buffer of arbitrary depth; the read port is a plain read of storage at rd_ptr.
module out_fifo #(
   parameter int unsigned Width = 12,
   parameter int unsigned Depth = 3,
   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CountWidth = $clog2(Depth + 1)
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  push,
   input  logic                  pop,
   input  logic [Width-1:0]      wr_data,
   output logic [Width-1:0]      rd_data,
   output logic [CountWidth-1:0] count,
   output logic                  full,
   output logic                  empty
);

   logic [Width-1:0]    mem [Depth];
   logic [PtrWidth-1:0] wr_ptr;
   logic [PtrWidth-1:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   // Depth need not be a power of two, so wrap explicitly at the last slot.
   function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
      return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign full    = (count == CountWidth'(Depth));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/out_channel_drain.sv
// Buffers out-instruction words and drains them to a consumer, then reports completion.
// Defining OUT_CHECK_EN compares each drained word against the compiled-in Expected vector.
module out_channel_drain
   import out_channel_pkg::*;
#(
   parameter int unsigned MemoryElementWidth = DefaultWordWidth,
   parameter int unsigned NOut = 3,
   parameter int unsigned NExpected = 3,
   parameter logic [NExpected*MemoryElementWidth-1:0] Expected = '0,
   localparam int unsigned CountWidth = $clog2(NOut + 1)
) (
   input  logic                          clock,
   input  logic                          resetN,
   input  logic                          outValid,
   input  logic [MemoryElementWidth-1:0] outData,
   output logic                          outReady,
   input  logic                          programDone,
   output logic                          drainValid,
   output logic [MemoryElementWidth-1:0] drainData,
   input  logic                          drainReady,
   output logic [CountWidth-1:0]         count,
   output logic                          overflow,
   output logic                          finished,
   output logic                          success
);

   localparam int unsigned DrainedWidth = $clog2(NExpected + 2);

   state_t                  state;
   state_t                  next_state;
   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;
   logic                    mismatch;
   logic [DrainedWidth-1:0] drained_count;

   out_fifo #(
      .Width (MemoryElementWidth),
      .Depth (NOut)
   ) fifo (
      .clock   (clock),
      .resetN  (resetN),
      .push    (push),
      .pop     (pop),
      .wr_data (outData),
      .rd_data (drainData),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // Handshake outputs come only from registered state, never from outValid/drainReady.
   assign outReady   = (state == RUN) && !full;
   assign drainValid = (state != DONE) && !empty;
   assign push       = outValid && outReady;
   assign pop        = drainValid && drainReady;
   assign finished   = (state == DONE);
   assign success    = finished && !overflow && !mismatch &&
                       (drained_count == DrainedWidth'(NExpected));

   always_comb begin
      next_state = state;
      case (state)
         RUN:     if (programDone) next_state = FLUSH;
         FLUSH:   if (count == '0) next_state = DONE;
         DONE:    next_state = DONE;
         default: next_state = RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state         <= RUN;
         overflow      <= 1'b0;
         drained_count <= '0;
      end else begin
         state <= next_state;
         if (outValid && !outReady) begin
            overflow <= 1'b1;
         end
         if (pop && (drained_count != DrainedWidth'(NExpected + 1))) begin
            drained_count <= drained_count + 1'b1;
         end
      end
   end

`ifdef OUT_CHECK_EN
   logic [MemoryElementWidth-1:0] expected_head;

   always_comb begin
      expected_head = '0;
      for (int k = 0; k < int'(NExpected); k++) begin
         if (drained_count == DrainedWidth'(k)) begin
            expected_head = Expected[k*MemoryElementWidth +: MemoryElementWidth];
         end
      end
   end

   // Any pop beyond the expected program length is itself a mismatch.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         mismatch <= 1'b0;
      end else if (pop) begin
         if (drained_count >= DrainedWidth'(NExpected)) begin
            mismatch <= 1'b1;
         end else if (drainData != expected_head) begin
            mismatch <= 1'b1;
         end
      end
   end
`else
   logic unused_expected;

   assign mismatch        = 1'b0;
   assign unused_expected = ^Expected;
`endif

endmodule

// File: tb/tb_out_channel_drain.sv
// Self-checking bench for out_channel_drain: vector table plus a drain-order scoreboard.
module tb_out_channel_drain;
   import out_channel_pkg::*;

   localparam int unsigned W    = 12;
   localparam int unsigned NOUT = 3;
   localparam int unsigned NEXP = 3;
   localparam logic [NEXP*W-1:0] EXP = {12'd3, 12'd2, 12'd1};
`ifdef OUT_CHECK_EN
   localparam bit CheckOn = 1'b1;
`else
   localparam bit CheckOn = 1'b0;
`endif

   typedef struct {
      bit    rst;
      bit    ov;
      word_t od;
      bit    dr;
      bit    pd;
      bit    acc;
      int    cnt;
      bit    ordy;
      bit    dv;
      bit    ovf;
      bit    fin;
      bit    succ;
   } vec_t;

   logic       clock;
   logic       resetN;
   logic       outValid;
   word_t      outData;
   logic       outReady;
   logic       programDone;
   logic       drainValid;
   word_t      drainData;
   logic       drainReady;
   logic [1:0] count;
   logic       overflow;
   logic       finished;
   logic       success;

   int    checks = 0;
   int    errors = 0;
   word_t sb[$];
   vec_t  vecs[$];

   out_channel_drain #(
      .MemoryElementWidth (W),
      .NOut               (NOUT),
      .NExpected          (NEXP),
      .Expected           (EXP)
   ) dut (
      .clock       (clock),
      .resetN      (resetN),
      .outValid    (outValid),
      .outData     (outData),
      .outReady    (outReady),
      .programDone (programDone),
      .drainValid  (drainValid),
      .drainData   (drainData),
      .drainReady  (drainReady),
      .count       (count),
      .overflow    (overflow),
      .finished    (finished),
      .success     (success)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs; words the bench expects to be accepted enter the scoreboard.
   task automatic applyStimulus(input bit rst, input bit ov, input word_t od, input bit dr,
                                input bit pd, input bit acc);
      resetN      = !rst;
      outValid    = ov;
      outData     = od;
      drainReady  = dr;
      programDone = pd;
      if (rst) sb.delete();
      else if (ov && acc) sb.push_back(od);
      @(posedge clock);
      #1;
   endtask

   function automatic vec_t mk(input bit rst, input bit ov, input int od, input bit dr,
                               input bit pd, input bit acc, input int cnt, input bit ordy,
                               input bit dv, input bit ovf, input bit fin, input bit succ);
      vec_t v;
      v.rst = rst; v.ov = ov; v.od = word_t'(od); v.dr = dr; v.pd = pd; v.acc = acc;
      v.cnt = cnt; v.ordy = ordy; v.dv = dv; v.ovf = ovf; v.fin = fin; v.succ = succ;
      return v;
   endfunction

   // Every handshaked drain must match the oldest outstanding accepted word.
   always @(negedge clock) begin : monitor
      word_t exp_word;
      if (resetN === 1'b1 && drainValid === 1'b1 && drainReady === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_unexpected: got %0d expected none", drainData);
         end else begin
            exp_word = sb.pop_front();
            checkOutput("drain_order", 32'(drainData), 32'(exp_word));
         end
      end
   end

   initial begin
      resetN = 1'b0; outValid = 1'b0; outData = '0; drainReady = 1'b0; programDone = 1'b0;

      // basic program 1,2,3 with consumer always ready
      vecs.push_back(mk(1,0, 0,0,0,0, 0,1,0,0,0,0));
      vecs.push_back(mk(0,1, 1,1,0,1, 1,1,1,0,0,0));
      vecs.push_back(mk(0,1, 2,1,0,1, 1,1,1,0,0,0));
      vecs.push_back(mk(0,1, 3,1,0,1, 1,1,1,0,0,0));
      vecs.push_back(mk(0,0, 0,1,1,0, 0,0,0,0,0,0));
      vecs.push_back(mk(0,0, 0,1,0,0, 0,0,0,0,1,1));
      vecs.push_back(mk(0,0, 0,1,0,0, 0,0,0,0,1,1));
      // fill to full, overflow, pop while full blocks the push
      vecs.push_back(mk(1,0, 0,0,0,0, 0,1,0,0,0,0));
      vecs.push_back(mk(0,1,10,0,0,1, 1,1,1,0,0,0));
      vecs.push_back(mk(0,1,11,0,0,1, 2,1,1,0,0,0));
      vecs.push_back(mk(0,1,12,0,0,1, 3,0,1,0,0,0));
      vecs.push_back(mk(0,1,13,0,0,0, 3,0,1,1,0,0));
      vecs.push_back(mk(0,1,14,1,0,0, 2,1,1,1,0,0));
      vecs.push_back(mk(0,0, 0,1,0,0, 1,1,1,1,0,0));
      vecs.push_back(mk(0,0, 0,1,1,0, 0,0,0,1,0,0));
      vecs.push_back(mk(0,0, 0,1,0,0, 0,0,0,1,1,0));
      // program emits 1,5,3 against expected 1,2,3
      vecs.push_back(mk(1,0, 0,0,0,0, 0,1,0,0,0,0));
      vecs.push_back(mk(0,1, 1,1,0,1, 1,1,1,0,0,0));
      vecs.push_back(mk(0,1, 5,1,0,1, 1,1,1,0,0,0));
      vecs.push_back(mk(0,1, 3,1,0,1, 1,1,1,0,0,0));
      vecs.push_back(mk(0,0, 0,1,1,0, 0,0,0,0,0,0));
      vecs.push_back(mk(0,0, 0,1,0,0, 0,0,0,0,1,!CheckOn));
      // empty program, then a push attempt while DONE
      vecs.push_back(mk(1,0, 0,0,0,0, 0,1,0,0,0,0));
      vecs.push_back(mk(0,0, 0,1,1,0, 0,0,0,0,0,0));
      vecs.push_back(mk(0,0, 0,1,0,0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,1, 7,1,0,0, 0,0,0,1,1,0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].ov, vecs[i].od, vecs[i].dr, vecs[i].pd, vecs[i].acc);
         checkOutput($sformatf("v%0d_count", i),    32'(count),    32'(vecs[i].cnt));
         checkOutput($sformatf("v%0d_outReady", i), 32'(outReady), 32'(vecs[i].ordy));
         checkOutput($sformatf("v%0d_drainValid", i), 32'(drainValid), 32'(vecs[i].dv));
         checkOutput($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
         checkOutput($sformatf("v%0d_finished", i), 32'(finished), 32'(vecs[i].fin));
         checkOutput($sformatf("v%0d_success", i),  32'(success),  32'(vecs[i].succ));
      end
      checkOutput("table_sb_empty", 32'(sb.size()), 32'd0);

      // steady state at count 2 with simultaneous push and pop, pointers wrap
      applyStimulus(1, 0, word_t'(0), 0, 0, 0);
      applyStimulus(0, 1, word_t'(100), 0, 0, 1);
      applyStimulus(0, 1, word_t'(101), 0, 0, 1);
      checkOutput("wrap_fill_count", 32'(count), 32'd2);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1, word_t'(102 + i), 1, 0, 1);
         checkOutput($sformatf("wrap%0d_count", i), 32'(count), 32'd2);
         checkOutput($sformatf("wrap%0d_outReady", i), 32'(outReady), 32'd1);
      end
      applyStimulus(0, 0, word_t'(0), 1, 0, 0);
      applyStimulus(0, 0, word_t'(0), 1, 0, 0);
      checkOutput("wrap_drained_count", 32'(count), 32'd0);
      checkOutput("wrap_sb_empty", 32'(sb.size()), 32'd0);

      // reset in the middle of a flush, then a clean program
      applyStimulus(1, 0, word_t'(0), 0, 0, 0);
      applyStimulus(0, 1, word_t'(1), 0, 0, 1);
      applyStimulus(0, 1, word_t'(2), 0, 0, 1);
      applyStimulus(0, 0, word_t'(0), 0, 1, 0);
      checkOutput("flush_count", 32'(count), 32'd2);
      checkOutput("flush_outReady", 32'(outReady), 32'd0);
      applyStimulus(1, 0, word_t'(0), 0, 0, 0);
      checkOutput("midreset_count", 32'(count), 32'd0);
      checkOutput("midreset_drainValid", 32'(drainValid), 32'd0);
      checkOutput("midreset_finished", 32'(finished), 32'd0);
      checkOutput("midreset_outReady", 32'(outReady), 32'd1);
      applyStimulus(0, 1, word_t'(1), 1, 0, 1);
      applyStimulus(0, 1, word_t'(2), 1, 0, 1);
      applyStimulus(0, 1, word_t'(3), 1, 0, 1);
      applyStimulus(0, 0, word_t'(0), 1, 1, 0);
      checkOutput("rerun_not_done", 32'(finished), 32'd0);
      applyStimulus(0, 0, word_t'(0), 1, 0, 0);
      checkOutput("rerun_finished", 32'(finished), 32'd1);
      checkOutput("rerun_success", 32'(success), 32'd1);
      checkOutput("rerun_sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
